// File: rtl/door_actuator_model_pkg.sv
// rtl/door_actuator_model_pkg.sv - door model state enum, default geometry and position width helper
package door_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        FAULT     = 2'd3
    } door_state_t;

    localparam int DEF_TRAVEL_STEPS = 200;
    localparam int DEF_STEP_DIV     = 2000;

    function automatic int pos_width(input int travel_steps);
        return (travel_steps < 1) ? 1 : $clog2(travel_steps + 1);
    endfunction

endpackage

// File: rtl/door_actuator_model_if.sv
// rtl/door_actuator_model_if.sv - motor command / end-stop sensor bundle (DOOR_OBSTACLE_EN adds obstacle)
interface door_actuator_model_if
    import door_pkg::*;
#(
    parameter int PW = pos_width(DEF_TRAVEL_STEPS)
);
    logic          ml;
    logic          mr;
`ifdef DOOR_OBSTACLE_EN
    logic          obstacle;
`endif
    logic          sense_up;
    logic          sense_down;
    logic [PW-1:0] position;
    logic          moving_up;
    logic          moving_down;
    logic          fault;

`ifdef DOOR_OBSTACLE_EN
    modport master (output ml, mr, obstacle,
                    input  sense_up, sense_down, position, moving_up, moving_down, fault);
    modport slave  (input  ml, mr, obstacle,
                    output sense_up, sense_down, position, moving_up, moving_down, fault);
`else
    modport master (output ml, mr,
                    input  sense_up, sense_down, position, moving_up, moving_down, fault);
    modport slave  (input  ml, mr,
                    output sense_up, sense_down, position, moving_up, moving_down, fault);
`endif

endinterface

// File: rtl/door_step_prescaler.sv
// rtl/door_step_prescaler.sv - step-rate divider: pulses on the cycle it wraps from STEP_DIV-1 to 0
module door_step_prescaler #(
    parameter int STEP_DIV = 2000
) (
    input  logic clk2m,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic step_o
);
    localparam int              CW   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tc;

    assign tc     = (cnt_q == LAST);
    assign step_o = enable_i && !clear_i && tc;

    // Clear wins over enable so a state change always discards the partial step.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/door_actuator_model.sv
// rtl/door_actuator_model.sv - garage door mechanism model: motor commands in, position and end stops out
// Optional light-barrier freeze of downward travel is enabled with DOOR_OBSTACLE_EN.
module door_actuator_model
    import door_pkg::*;
#(
    parameter int TRAVEL_STEPS = DEF_TRAVEL_STEPS,
    parameter int STEP_DIV     = DEF_STEP_DIV
) (
    input  logic                  clk2m,
    input  logic                  rst_n,
    door_actuator_model_if.slave  dif
);
    localparam int            PW  = pos_width(TRAVEL_STEPS);
    localparam logic [PW-1:0] TOP = PW'(TRAVEL_STEPS);

    door_state_t   state_q;
    door_state_t   state_d;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_d;
    logic          sense_up_q;
    logic          sense_down_q;
    logic          moving_up_q;
    logic          moving_down_q;
    logic          fault_q;

    logic          at_top;
    logic          at_bottom;
    logic          blocked;
    logic          presc_en;
    logic          presc_clr;
    logic          step;

    // FAULT is absorbing; only reset leaves it.
    always_comb begin
        state_d = state_q;
        if (state_q != FAULT) begin
            unique case ({dif.ml, dif.mr})
                2'b11:   state_d = FAULT;
                2'b01:   state_d = MOVE_UP;
                2'b10:   state_d = MOVE_DOWN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign at_top    = (pos_q == TOP);
    assign at_bottom = (pos_q == '0);

`ifdef DOOR_OBSTACLE_EN
    assign blocked = dif.obstacle && (state_q == MOVE_DOWN);
`else
    assign blocked = 1'b0;
`endif

    assign presc_clr = (state_d != state_q);
    assign presc_en  = !presc_clr && !blocked &&
                       (((state_q == MOVE_UP)   && !at_top) ||
                        ((state_q == MOVE_DOWN) && !at_bottom));

    door_step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk2m    (clk2m),
        .rst_n    (rst_n),
        .enable_i (presc_en),
        .clear_i  (presc_clr),
        .step_o   (step)
    );

    always_comb begin
        pos_d = pos_q;
        if (step) begin
            pos_d = (state_q == MOVE_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
        end
    end

    // Sensors derive from pos_d so they toggle on the same edge as position.
    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pos_q         <= '0;
            sense_up_q    <= 1'b0;
            sense_down_q  <= 1'b1;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            sense_up_q    <= (pos_d == TOP);
            sense_down_q  <= (pos_d == '0);
            moving_up_q   <= (state_d == MOVE_UP);
            moving_down_q <= (state_d == MOVE_DOWN);
            fault_q       <= (state_d == FAULT);
        end
    end

    assign dif.position    = pos_q;
    assign dif.sense_up    = sense_up_q;
    assign dif.sense_down  = sense_down_q;
    assign dif.moving_up   = moving_up_q;
    assign dif.moving_down = moving_down_q;
    assign dif.fault       = fault_q;

endmodule
